// File: rtl/conva1_accumulate.sv
// conva1_accumulate: post-convolution stage for layer A1.
// Each accepted beat carries one partial sum per convolution unit for a single
// output pixel. The partials are summed, the filter's bias is added, the
// result is saturated and passed through ReLU, and then written out together
// with its pixel address and output-map select. A small FSM tracks the layer
// pass and signals completion.
//
// Handshake: there is no backpressure. A beat is consumed on any rising edge
// where the FSM is in RUN and in_valid is 1. Every consumed beat produces
// exactly one ofm_write_enable cycle two edges later. in_valid is ignored in
// all other states.
module conva1_accumulate #(
    parameter int DATA_WIDTH                  = 32,
    parameter int IFM_SIZE                    = 32,
    parameter int KERNAL_SIZE                 = 5,
    parameter int NUMBER_OF_FILTERS           = 6,
    parameter int NUMBER_OF_UNITS             = 3,
    parameter int IFM_SIZE_NEXT               = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_NEXT_IFM       = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int NUMBER_OF_BITS_SEL_IFM_NEXT = $clog2(NUMBER_OF_FILTERS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   in_valid,
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]  unit_data_in,
    input  logic [DATA_WIDTH-1:0]                  riscv_data,
    input  logic                                   bias_write,
    input  logic [NUMBER_OF_BITS_SEL_IFM_NEXT-1:0] bias_sel,
    output logic [DATA_WIDTH-1:0]                  ofm_data_out,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0]       ofm_address,
    output logic [NUMBER_OF_BITS_SEL_IFM_NEXT-1:0] ofm_sel,
    output logic                                   ofm_write_enable,
    output logic                                   busy,
    output logic                                   done
);

    // Widened accumulation width: room for the unit sum plus the bias.
    localparam int ACC_W = DATA_WIDTH + $clog2(NUMBER_OF_UNITS) + 1;
    localparam int AW    = ADDRESS_SIZE_NEXT_IFM;
    localparam int SW    = NUMBER_OF_BITS_SEL_IFM_NEXT;
    localparam int EXT_W = ACC_W - DATA_WIDTH;

    localparam logic [AW-1:0] PIX_LAST  = AW'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
    localparam logic [SW-1:0] FILT_LAST = SW'(NUMBER_OF_FILTERS - 1);
    localparam logic [SW:0]   NUM_FILT  = (SW + 1)'(NUMBER_OF_FILTERS);

    // Largest positive value representable in DATA_WIDTH, at both widths.
    localparam logic signed [ACC_W-1:0] SAT_MAX_ACC =
        {{(EXT_W + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MAX_OUT =
        {1'b0, {(DATA_WIDTH - 1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // FSM and position tracking
    state_t        state_q;
    logic [AW-1:0] pix_q;
    logic [SW-1:0] filt_q;
    logic          flush_cnt_q;
    logic          busy_q;
    logic          done_q;

    // Bias storage
    logic [DATA_WIDTH-1:0] bias_q [NUMBER_OF_FILTERS];
    logic                  bias_sel_ok;

    // Stage 1: summed partials with the beat's bias and position
    logic                         accept;
    logic signed [ACC_W-1:0]      sum_d;
    logic                         valid1_q;
    logic signed [ACC_W-1:0]      sum1_q;
    logic [DATA_WIDTH-1:0]        bias1_q;
    logic [AW-1:0]                pix1_q;
    logic [SW-1:0]                filt1_q;

    // Stage 2: biased, saturated, activated result
    logic signed [ACC_W-1:0]      acc_d;
    logic [DATA_WIDTH-1:0]        result_d;
    logic                         we_q;
    logic [DATA_WIDTH-1:0]        data_q;
    logic [AW-1:0]                addr_q;
    logic [SW-1:0]                sel_q;

    assign accept      = (state_q == S_RUN) && in_valid;
    assign bias_sel_ok = ({1'b0, bias_sel} < NUM_FILT);

    // Layer-pass FSM with pixel/filter counters and registered busy/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pix_q       <= '0;
            filt_q      <= '0;
            flush_cnt_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        pix_q   <= '0;
                        filt_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        if (pix_q == PIX_LAST) begin
                            pix_q <= '0;
                            if (filt_q == FILT_LAST) begin
                                // Final beat of the layer: let the two
                                // pipeline stages drain before reporting done.
                                filt_q      <= '0;
                                flush_cnt_q <= 1'b0;
                                state_q     <= S_FLUSH;
                            end else begin
                                filt_q <= filt_q + 1'b1;
                            end
                        end else begin
                            pix_q <= pix_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        flush_cnt_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bias register file, writable at any time; out-of-range indices dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
                bias_q[i] <= '0;
            end
        end else if (bias_write && bias_sel_ok) begin
            bias_q[bias_sel] <= riscv_data;
        end
    end

    // Adder tree: sign-extend every unit partial and sum at the wide width.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
            sum_d = sum_d + {{EXT_W{unit_data_in[k*DATA_WIDTH + DATA_WIDTH - 1]}},
                             unit_data_in[k*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    // Stage 1 register. The bias is captured together with the beat, so a
    // bias_write landing in the same cycle only affects later beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid1_q <= 1'b0;
            sum1_q   <= '0;
            bias1_q  <= '0;
            pix1_q   <= '0;
            filt1_q  <= '0;
        end else begin
            valid1_q <= accept;
            if (accept) begin
                sum1_q  <= sum_d;
                bias1_q <= bias_q[filt_q];
                pix1_q  <= pix_q;
                filt1_q <= filt_q;
            end
        end
    end

    // Bias add, saturation to the positive DATA_WIDTH limit, then ReLU.
    always_comb begin
        acc_d = sum1_q + {{EXT_W{bias1_q[DATA_WIDTH-1]}}, bias1_q};
        if (acc_d[ACC_W-1]) begin
            result_d = '0;
        end else if (acc_d > SAT_MAX_ACC) begin
            result_d = SAT_MAX_OUT;
        end else begin
            result_d = acc_d[DATA_WIDTH-1:0];
        end
    end

    // Stage 2 register: result, address and select leave together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q   <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
            sel_q  <= '0;
        end else begin
            we_q <= valid1_q;
            if (valid1_q) begin
                data_q <= result_d;
                addr_q <= pix1_q;
                sel_q  <= filt1_q;
            end
        end
    end

    assign ofm_data_out     = data_q;
    assign ofm_address      = addr_q;
    assign ofm_sel          = sel_q;
    assign ofm_write_enable = we_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_conva1_accumulate.sv
// Testbench for conva1_accumulate. Directed sequence of steps with random
// partial data; expected writes, done and busy come from a plain arithmetic
// model of the layer pass kept in this file.
module tb_conva1_accumulate;

    localparam int DW    = 32;
    localparam int NU    = 3;
    localparam int NF    = 6;
    localparam int SIDE  = 28;
    localparam int PIX   = SIDE * SIDE;
    localparam int AW    = 10;
    localparam int SW    = 3;
    localparam int NEVER = 1 << 30;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 in_valid;
    logic [NU*DW-1:0]     unit_data_in;
    logic [DW-1:0]        riscv_data;
    logic                 bias_write;
    logic [SW-1:0]        bias_sel;
    logic [DW-1:0]        ofm_data_out;
    logic [AW-1:0]        ofm_address;
    logic [SW-1:0]        ofm_sel;
    logic                 ofm_write_enable;
    logic                 busy;
    logic                 done;

    conva1_accumulate dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_valid         (in_valid),
        .unit_data_in     (unit_data_in),
        .riscv_data       (riscv_data),
        .bias_write       (bias_write),
        .bias_sel         (bias_sel),
        .ofm_data_out     (ofm_data_out),
        .ofm_address      (ofm_address),
        .ofm_sel          (ofm_sel),
        .ofm_write_enable (ofm_write_enable),
        .busy             (busy),
        .done             (done)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] bias_m [NF];
    bit            run_m      = 1'b0;
    int            beat_idx   = 0;
    int            start_edge = NEVER;
    int            done_edge  = NEVER;
    int            idle_edge  = 0;
    bit            chk_en     = 1'b0;
    int            n_cmp      = 0;
    int            n_err      = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sum of signed partials plus signed bias, clamped to [0, 2^31-1].
    function automatic logic [DW-1:0] ref_out(input logic [NU*DW-1:0] d, input logic [DW-1:0] b);
        longint s;
        s = longint'($signed(b));
        for (int k = 0; k < NU; k++) s += longint'($signed(d[k*DW +: DW]));
        if (s < 0) return '0;
        if (s > 64'sd2147483647) return 32'h7fff_ffff;
        return s[DW-1:0];
    endfunction

    function automatic logic [NU*DW-1:0] pack3(input int a, input int b, input int c);
        return {32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [NU*DW-1:0] rnd3();
        logic [NU*DW-1:0] d;
        for (int k = 0; k < NU; k++) begin
            if ($urandom_range(0, 1) == 1) d[k*DW +: DW] = $urandom;
            else d[k*DW +: DW] = 32'(int'($urandom_range(0, 4000)) - 2000);
        end
        return d;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            bit   we_exp;
            we_exp = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
            chk("write_enable", 64'(ofm_write_enable), 64'(we_exp));
            if (we_exp) begin
                e = exp_q.pop_front();
                chk("data", 64'(ofm_data_out), 64'(e.data));
                chk("address", 64'(ofm_address), 64'(e.addr));
                chk("sel", 64'(ofm_sel), 64'(e.sel));
            end
            chk("done", 64'(done), 64'(edge_cnt == done_edge));
            chk("busy", 64'(busy), 64'(edge_cnt >= start_edge && edge_cnt <= done_edge));
        end
    end

    // ---------------- driver ----------------
    // Drives one cycle of inputs (sampled at the next rising edge) and
    // updates the model with what the DUT should make of them.
    task automatic step(input bit v, input logic [NU*DW-1:0] d, input bit st,
                        input bit bw, input int bs, input logic [DW-1:0] bd);
        int   e;
        exp_t x;
        e            = edge_cnt + 1;
        in_valid     = v;
        unit_data_in = d;
        start        = st;
        bias_write   = bw;
        bias_sel     = SW'(bs);
        riscv_data   = bd;
        if (v && run_m) begin
            x.due  = e + 1;
            x.addr = AW'(beat_idx % PIX);
            x.sel  = SW'(beat_idx / PIX);
            x.data = ref_out(d, bias_m[beat_idx / PIX]);
            exp_q.push_back(x);
            beat_idx++;
            if (beat_idx == NF * PIX) begin
                run_m     = 1'b0;
                done_edge = e + 2;
                idle_edge = e + 4;
            end
        end
        if (st && !run_m && e >= idle_edge) begin
            run_m      = 1'b1;
            beat_idx   = 0;
            start_edge = e;
            done_edge  = NEVER;
        end
        if (bw && bs < NF) bias_m[bs] = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"}, 64'(ofm_data_out), 64'd0);
        chk({tag, "_address"}, 64'(ofm_address), 64'd0);
        chk({tag, "_sel"}, 64'(ofm_sel), 64'd0);
        chk({tag, "_write_enable"}, 64'(ofm_write_enable), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        in_valid     = 1'b0;
        unit_data_in = '0;
        riscv_data   = '0;
        bias_write   = 1'b0;
        bias_sel     = '0;
        for (int i = 0; i < NF; i++) bias_m[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        chk_en = 1'b1;
        reset  = 1'b1;
        @(posedge clk);
        #1;

        // Biases while idle, including out-of-range indices that must be dropped.
        step(0, '0, 0, 1, 0, 32'd5);
        step(0, '0, 0, 1, 1, 32'd100);
        for (int i = 2; i < NF; i++) step(0, '0, 0, 1, i, 32'($urandom_range(0, 50)));
        step(0, '0, 0, 1, 6, 32'hdead_beef);
        step(0, '0, 0, 1, 7, 32'h1234_5678);

        // in_valid while idle: no writes.
        repeat (3) step(1, rnd3(), 0, 0, 0, '0);

        // Pass 1: full layer.
        step(0, '0, 1, 0, 0, '0);
        step(1, pack3(1, 2, 3), 0, 0, 0, '0);
        step(1, pack3(-20, 2, 3), 0, 0, 0, '0);
        step(1, pack3(32'h7fffffff, 32'h7fffffff, 32'h7fffffff), 0, 0, 0, '0);
        step(1, pack3(32'h80000000, 32'h80000000, 32'h80000000), 0, 0, 0, '0);
        for (int i = 0; i < 40; i++) step((i % 2) == 0, rnd3(), 0, 0, 0, '0);
        step(1, rnd3(), 1, 0, 0, '0);
        step(1, rnd3(), 0, 1, 7, 32'h0000_1234);
        while (beat_idx < PIX) step(1, rnd3(), 0, 0, 0, '0);
        step(1, pack3(10, 20, 30), 0, 1, 1, 32'd7);
        step(1, pack3(10, 20, 30), 0, 0, 0, '0);
        while (run_m) step(1, rnd3(), 0, 0, 0, '0);
        repeat (6) step(1, rnd3(), 0, 0, 0, '0);

        // Pass 2: reset in the middle of filter 2.
        step(0, '0, 1, 0, 0, '0);
        while (beat_idx < 2 * PIX + 100) step(1, rnd3(), 0, 0, 0, '0);
        step(1, rnd3(), 0, 0, 0, '0);
        reset = 1'b0;
        exp_q.delete();
        run_m      = 1'b0;
        start_edge = NEVER;
        done_edge  = NEVER;
        idle_edge  = 0;
        for (int i = 0; i < NF; i++) bias_m[i] = '0;
        in_valid   = 1'b0;
        start      = 1'b0;
        bias_write = 1'b0;
        #1;
        check_outputs_zero("midpass_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Pass 3: restart from address 0, select 0.
        step(0, '0, 1, 0, 0, '0);
        step(1, pack3(4, 5, 6), 0, 0, 0, '0);
        repeat (10) step(1, rnd3(), 0, 0, 0, '0);
        repeat (4) step(0, '0, 0, 0, 0, '0);

        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
